// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
// Frame-level controller between the byte-oriented SPI slave and the
// control/status register bus. The first byte of a frame is a command
// (bit7 = read, low bits = start address). It is followed either by write
// data bytes or by auto-incrementing register reads that are returned on MISO.
module spi_cmd_ctrl #(
  parameter int          ADDR_W    = 7,
  parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [7:0]        rxd_data,
  input  logic              rxd_flag,
  output logic [7:0]        txd_data,
  output logic              txd_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              frame_active,
  output logic [7:0]        byte_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_FETCH,
    RD_WAIT,
    RD_DATA
  } state_t;

  state_t state;

  // Chip-select synchronizer stages plus one history flop for edge detection.
  logic cs_meta;
  logic cs_s;
  logic cs_prev;
  logic frame_start;
  logic frame_end;

  assign frame_start = cs_prev & ~cs_s;
  assign frame_end   = ~cs_prev & cs_s;

  // Bring the raw chip select into clk; frame_active tracks the synchronized
  // level, so it is loaded from the same stage that feeds cs_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta      <= 1'b1;
      cs_s         <= 1'b1;
      cs_prev      <= 1'b1;
      frame_active <= 1'b0;
    end else begin
      cs_meta      <= cs_n;
      cs_s         <= cs_meta;
      cs_prev      <= cs_s;
      frame_active <= ~cs_meta;
    end
  end

  // Count the bytes of the current frame, saturating at 255. The count is
  // cleared only when the next frame starts, so software can still read it
  // after CS has gone high. A byte coinciding with frame end is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 8'd0;
    end else if (frame_start) begin
      byte_cnt <= 8'd0;
    end else if (rxd_flag && !cs_s && (byte_cnt != 8'hFF)) begin
      byte_cnt <= byte_cnt + 8'd1;
    end
  end

  // Protocol sequencer. Strobes default low every cycle so each one is a
  // single-cycle pulse. Frame end takes priority in every state and discards
  // whatever was in flight, including a pending read result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      txd_data  <= IDLE_BYTE;
      txd_load  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      txd_load <= 1'b0;
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      if (frame_end) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // Preload the idle pattern so it is shifted out during the
            // command slot.
            if (frame_start) begin
              state    <= CMD;
              txd_data <= IDLE_BYTE;
              txd_load <= 1'b1;
            end
          end
          CMD: begin
            if (rxd_flag) begin
              reg_addr <= rxd_data[ADDR_W-1:0];
              if (rxd_data[7]) begin
                // reg_re is registered, so raise it on entry to RD_FETCH
                // to have it coincide with that state.
                state  <= RD_FETCH;
                reg_re <= 1'b1;
              end else begin
                state <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            // Advance the address the cycle after the write strobe; bytes
            // are at least two cycles apart, so the next write sees it.
            if (reg_we) begin
              reg_addr <= reg_addr + ADDR_W'(1);
            end
            if (rxd_flag) begin
              reg_we    <= 1'b1;
              reg_wdata <= rxd_data;
            end
          end
          RD_FETCH: begin
            // Bytes arriving here or in RD_WAIT are only counted; no
            // extra fetch is queued.
            state <= RD_WAIT;
          end
          RD_WAIT: begin
            // reg_rdata is valid this cycle, one cycle after reg_re.
            txd_data <= reg_rdata;
            txd_load <= 1'b1;
            reg_addr <= reg_addr + ADDR_W'(1);
            state    <= RD_DATA;
          end
          RD_DATA: begin
            // The master has clocked out the loaded byte; fetch the next.
            if (rxd_flag) begin
              state  <= RD_FETCH;
              reg_re <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: table of whole frames checked against
// hand-computed strobe addresses, data and timing, plus directed sequences
// for abort, coincident frame end, byte count saturation and mid-frame reset.
module tb_spi_cmd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic [7:0] rxd_data;
  logic       rxd_flag;
  logic [7:0] txd_data;
  logic       txd_load;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       frame_active;
  logic [7:0] byte_cnt;

  spi_cmd_ctrl #(
    .ADDR_W   (7),
    .IDLE_BYTE(8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_n        (cs_n),
    .rxd_data    (rxd_data),
    .rxd_flag    (rxd_flag),
    .txd_data    (txd_data),
    .txd_load    (txd_load),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .frame_active(frame_active),
    .byte_cnt    (byte_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-only register file model: data valid one cycle after reg_re.
  logic [7:0] regs [128];
  initial reg_rdata = 8'h00;
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= regs[reg_addr];
  end

  // Strobe monitor, sampled mid-cycle.
  logic [6:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  int         we_cyc_q[$];
  logic [6:0] re_addr_q[$];
  int         re_cyc_q[$];
  logic [7:0] ld_data_q[$];
  int         ld_cyc_q[$];
  int         flag_q[$];
  int         multi_strobe = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin
        we_addr_q.push_back(reg_addr);
        we_data_q.push_back(reg_wdata);
        we_cyc_q.push_back(cyc);
      end
      if (reg_re) begin
        re_addr_q.push_back(reg_addr);
        re_cyc_q.push_back(cyc);
      end
      if (txd_load) begin
        ld_data_q.push_back(txd_data);
        ld_cyc_q.push_back(cyc);
      end
      if ((int'(reg_we) + int'(reg_re) + int'(txd_load)) > 1) multi_strobe++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    we_addr_q.delete(); we_data_q.delete(); we_cyc_q.delete();
    re_addr_q.delete(); re_cyc_q.delete();
    ld_data_q.delete(); ld_cyc_q.delete();
    flag_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rxd_data = b;
    rxd_flag = 1'b1;
    flag_q.push_back(cyc);
    step(1);
    rxd_flag = 1'b0;
    step(gap);
  endtask

  task automatic frame_begin();
    clear_q();
    cs_n = 1'b0;
    step(4);
    chk("frame_active_in", frame_active, 1);
    chk("byte_cnt_start", byte_cnt, 0);
  endtask

  task automatic frame_finish();
    cs_n = 1'b1;
    step(4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_txd_data"}, txd_data, 8'hA5);
    chk({tag, "_txd_load"}, txd_load, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_reg_we"}, reg_we, 0);
    chk({tag, "_reg_re"}, reg_re, 0);
    chk({tag, "_frame_active"}, frame_active, 0);
    chk({tag, "_byte_cnt"}, byte_cnt, 0);
  endtask

  typedef struct {
    bit              is_read;
    int              nbytes;
    logic [3:0][7:0] bytes;     // bytes[0] is the command
    int              n_exp;
    logic [2:0][7:0] exp_addr;  // expected strobe addresses in order
    logic [2:0][7:0] exp_data;  // write data, or loaded read data
  } vec_t;

  vec_t vecs[4];

  initial begin
    for (int a = 0; a < 128; a++) regs[a] = 8'h00;
    regs[7'h10] = 8'hDE;
    regs[7'h11] = 8'hAD;
    regs[7'h12] = 8'h77;
    regs[7'h7F] = 8'h5C;
    regs[7'h00] = 8'h3C;
    regs[7'h01] = 8'hC3;

    vecs[0] = '{1'b0, 4, 32'h33221105, 3, 24'h070605, 24'h332211};
    vecs[1] = '{1'b0, 3, 32'h00BBAA7F, 2, 24'h00007F, 24'h00BBAA};
    vecs[2] = '{1'b1, 3, 32'h00000090, 3, 24'h121110, 24'h77ADDE};
    vecs[3] = '{1'b1, 3, 32'h000000FF, 3, 24'h01007F, 24'hC33C5C};

    cs_n     = 1'b1;
    rxd_flag = 1'b0;
    rxd_data = 8'h00;
    rst_n    = 1'b0;
    step(3);
    chk_reset("rst_hold");
    rst_n = 1'b1;
    step(3);
    chk_reset("rst_idle");

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v = vecs[i];
      frame_begin();
      for (int j = 0; j < v.nbytes; j++) send_byte(v.bytes[j], 5);
      frame_finish();
      $display("frame %0d cmd=%02h bytes=%0d we=%0d re=%0d loads=%0d cnt=%0d",
               i, v.bytes[0], v.nbytes, we_addr_q.size(), re_addr_q.size(),
               ld_data_q.size(), byte_cnt);
      chk("byte_cnt_end", byte_cnt, v.nbytes);
      chk("frame_active_end", frame_active, 0);
      chk("n_load", ld_data_q.size(), v.is_read ? v.n_exp + 1 : 1);
      if (ld_data_q.size() > 0) chk("idle_load", ld_data_q[0], 8'hA5);
      if (v.is_read) begin
        chk("n_we_rd", we_addr_q.size(), 0);
        chk("n_re", re_addr_q.size(), v.n_exp);
        for (int k = 0; k < v.n_exp; k++) begin
          if (k < re_addr_q.size()) begin
            chk("re_addr", re_addr_q[k], v.exp_addr[k]);
            chk("re_lat", re_cyc_q[k] - flag_q[k], 1);
          end
          if (k + 1 < ld_data_q.size()) begin
            chk("ld_data", ld_data_q[k+1], v.exp_data[k]);
            chk("ld_lat", ld_cyc_q[k+1] - flag_q[k], 3);
          end
        end
      end else begin
        chk("n_re_wr", re_addr_q.size(), 0);
        chk("n_we", we_addr_q.size(), v.n_exp);
        for (int k = 0; k < v.n_exp; k++) begin
          if (k < we_addr_q.size()) begin
            chk("we_addr", we_addr_q[k], v.exp_addr[k]);
            chk("we_data", we_data_q[k], v.exp_data[k]);
            chk("we_lat", we_cyc_q[k] - flag_q[k+1], 1);
          end
        end
      end
    end

    // Abort: CS rises in the command cycle so frame end lands in RD_WAIT.
    clear_q();
    cs_n = 1'b0;
    step(4);
    rxd_data = 8'h85;
    rxd_flag = 1'b1;
    cs_n     = 1'b1;
    step(1);
    rxd_flag = 1'b0;
    step(6);
    $display("abort frame re=%0d loads=%0d cnt=%0d", re_addr_q.size(), ld_data_q.size(), byte_cnt);
    chk("abort_n_re", re_addr_q.size(), 1);
    if (re_addr_q.size() > 0) chk("abort_re_addr", re_addr_q[0], 7'h05);
    chk("abort_n_load", ld_data_q.size(), 1);
    chk("abort_byte_cnt", byte_cnt, 1);

    // Next frame after abort starts cleanly with the idle byte.
    clear_q();
    cs_n = 1'b0;
    step(3);
    chk("restart_txd_load", txd_load, 1);
    chk("restart_txd_data", txd_data, 8'hA5);
    chk("restart_byte_cnt", byte_cnt, 0);
    step(1);
    send_byte(8'h01, 5);
    send_byte(8'h42, 5);
    frame_finish();
    $display("restart frame we=%0d cnt=%0d", we_addr_q.size(), byte_cnt);
    chk("restart_n_we", we_addr_q.size(), 1);
    if (we_addr_q.size() > 0) begin
      chk("restart_we_addr", we_addr_q[0], 7'h01);
      chk("restart_we_data", we_data_q[0], 8'h42);
    end

    // Byte coincident with frame end in WR_DATA must not write.
    frame_begin();
    send_byte(8'h20, 5);
    send_byte(8'h01, 5);
    cs_n = 1'b1;
    step(2);
    rxd_data = 8'h99;
    rxd_flag = 1'b1;
    step(1);
    rxd_flag = 1'b0;
    step(4);
    $display("coincident frame we=%0d cnt=%0d", we_addr_q.size(), byte_cnt);
    chk("coinc_n_we", we_addr_q.size(), 1);
    if (we_addr_q.size() > 0) chk("coinc_we_data", we_data_q[0], 8'h01);
    chk("coinc_byte_cnt", byte_cnt, 2);

    // 300 bytes in one frame saturate the counter.
    frame_begin();
    send_byte(8'h00, 1);
    for (int j = 1; j < 300; j++) send_byte(8'(j), 1);
    frame_finish();
    $display("long frame we=%0d cnt=%0d", we_addr_q.size(), byte_cnt);
    chk("sat_byte_cnt", byte_cnt, 255);
    chk("sat_n_we", we_addr_q.size(), 299);

    // Reset in the middle of a read frame returns everything to reset values.
    frame_begin();
    send_byte(8'h90, 5);
    chk("midrst_pre_txd", txd_data, 8'hDE);
    rst_n = 1'b0;
    step(1);
    chk_reset("midrst");
    cs_n = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(4);
    $display("mid-frame reset cnt=%0d active=%0d", byte_cnt, frame_active);
    chk_reset("post_rst");

    chk("strobe_overlap", multi_strobe, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
